// File: rtl/load_store_unit.sv
// RV64 load/store unit driving a doubleword-wide data memory.
// Sub-doubleword stores use read-modify-write, so data_mem only ever sees whole 64-bit writes.
module load_store_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            resp_illegal,
  output logic            mem_wrt_en,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] buf_q;
  logic            misaligned_q;
  logic            illegal_q;

  // Request decode, only consumed on the accepting edge.
  logic       req_illegal;
  logic       req_misaligned;
  logic [2:0] req_align_mask;

  always_comb begin
    req_illegal    = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    req_align_mask = 3'((4'd1 << req_funct3[1:0]) - 4'd1);
    req_misaligned = !req_illegal && |(req_addr[2:0] & req_align_mask);
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // on the same edge see pre-edge values; buf_q is a plain register and is reset like the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q   <= req_is_store;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            misaligned_q <= req_misaligned;
            illegal_q    <= req_illegal;
            if (req_illegal || req_misaligned)
              state <= RESP;
            else if (req_is_store && req_funct3[1:0] == 2'b11)
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          buf_q <= mem_read_data;
          state <= is_store_q ? WR : RESP;
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane selection shared by the store merge and the load extraction.
  logic [2:0]      offset;
  logic [7:0]      size_lanes;
  logic [7:0]      lane_mask;
  logic [XLEN-1:0] byte_mask;
  logic [XLEN-1:0] wdata_shifted;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] load_result;

  // NOTE: each combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    offset = addr_q[2:0];
    case (funct3_q[1:0])
      2'b00:   size_lanes = 8'h01;
      2'b01:   size_lanes = 8'h03;
      2'b10:   size_lanes = 8'h0F;
      default: size_lanes = 8'hFF;
    endcase
    lane_mask = size_lanes << offset;
    byte_mask = '0;
    for (int i = 0; i < 8; i++)
      byte_mask[8*i +: 8] = {8{lane_mask[i]}};
    wdata_shifted = wdata_q << {offset, 3'b000};
    merged        = (buf_q & ~byte_mask) | (wdata_shifted & byte_mask);

    rd_shifted = buf_q >> {offset, 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{(XLEN-8){rd_shifted[7]}},   rd_shifted[7:0]};
      3'b001:  load_result = {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_result = {{(XLEN-32){rd_shifted[31]}}, rd_shifted[31:0]};
      3'b011:  load_result = rd_shifted;
      3'b100:  load_result = {{(XLEN-8){1'b0}},  rd_shifted[7:0]};
      3'b101:  load_result = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      3'b110:  load_result = {{(XLEN-32){1'b0}}, rd_shifted[31:0]};
      default: load_result = '0;
    endcase
  end

  // Outputs decode from state and latched fields only; rst forces them all low.
  always_comb begin
    req_ready       = 1'b0;
    mem_wrt_en      = 1'b0;
    mem_address     = '0;
    mem_write_data  = '0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    if (!rst) begin
      req_ready = (state == IDLE);
      if (state != IDLE)
        mem_address = {addr_q[XLEN-1:3], 3'b000};
      if (state == WR) begin
        mem_wrt_en     = 1'b1;
        mem_write_data = merged;
      end
      if (state == RESP) begin
        resp_valid      = 1'b1;
        resp_misaligned = misaligned_q;
        resp_illegal    = illegal_q;
        if (!is_store_q && !misaligned_q && !illegal_q)
          resp_rdata = load_result;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 512-byte data_mem model plus a byte-level
// reference memory that predicts load results, fault flags, latency and final contents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic        mem_wrt_en;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  load_store_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_wrt_en(mem_wrt_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // data_mem: combinational read, whole-word write on the rising edge.
  logic [63:0] dmem [64];
  assign mem_read_data = dmem[mem_address[8:3]];
  always @(posedge clk) if (mem_wrt_en) dmem[mem_address[8:3]] <= mem_write_data;

  // Reference memory, byte-addressed.
  logic [7:0] ref_bytes [512];

  int total = 0;
  int bad   = 0;
  logic [63:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int a);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[a + i];
    if (!f3[2] && n < 8)
      for (int i = 8*n; i < 64; i++) v[i] = v[8*n - 1];
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_bytes[w*8 + b];
    return v;
  endfunction

  // One complete request: issue, observe until the response, compare with the model.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    int ai = int'(a);
    logic ill = st ? f3[2] : (f3 == 3'b111);
    logic mis = !ill && (ai % n != 0);
    int exp_lat = (ill || mis) ? 1 : (!st || f3[1:0] == 2'b11) ? 2 : 3;
    logic exp_wr = st && !ill && !mis;
    logic [63:0] exp_rd = (!st && !ill && !mis) ? ref_load(f3, ai) : 64'd0;
    int lat = 0;
    int wr_cnt = 0;
    logic [63:0] wr_adr = '0;
    logic [63:0] rd = '0;
    logic mis_o = 1'b0;
    logic ill_o = 1'b0;
    logic got = 1'b0;
    int w = 0;

    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    check({tag, "_ready"}, req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin
      if (mem_wrt_en) begin wr_cnt++; wr_adr = mem_address; end
      if (resp_valid) begin
        got = 1'b1; lat = k; rd = resp_rdata; mis_o = resp_misaligned; ill_o = resp_illegal;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_mis"}, mis_o, mis);
    check({tag, "_ill"}, ill_o, ill);
    check({tag, "_wrcnt"}, wr_cnt, exp_wr ? 1 : 0);
    if (exp_wr) begin
      check({tag, "_wradr"}, wr_adr, a & ~64'd7);
      ref_store(f3, ai, wd);
    end
    last_rdata = rd;
  endtask

  initial begin
    logic [63:0] word;
    logic [63:0] exp1;
    logic [63:0] wd2;
    int events;

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 64; w++) begin
      word = (w == 0) ? 64'hFFAAFFAAFFAAFFAA :
             (w == 1) ? 64'h778899AABBCCDDEE : {$urandom, $urandom};
      dmem[w] = word;
      for (int b = 0; b < 8; b++) ref_bytes[w*8 + b] = word[8*b +: 8];
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_wrt_en", mem_wrt_en, 1'b0);
    check("rst_address", mem_address, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", req_ready, 1'b1);

    // Loads from the preload pattern, each also checked against a fixed constant.
    do_req("lb1", 1'b0, 3'b000, 64'd1, 64'd0);   check("lb1_k",  last_rdata, 64'hFFFFFFFFFFFFFFFF);
    do_req("lbu1", 1'b0, 3'b100, 64'd1, 64'd0);  check("lbu1_k", last_rdata, 64'h00000000000000FF);
    do_req("lh0", 1'b0, 3'b001, 64'd0, 64'd0);   check("lh0_k",  last_rdata, 64'hFFFFFFFFFFFFFFAA);
    do_req("lw12", 1'b0, 3'b010, 64'd12, 64'd0); check("lw12_k", last_rdata, 64'h00000000778899AA);
    do_req("lb11", 1'b0, 3'b000, 64'd11, 64'd0); check("lb11_k", last_rdata, 64'hFFFFFFFFFFFFFFBB);
    do_req("ld8", 1'b0, 3'b011, 64'd8, 64'd0);   check("ld8_k",  last_rdata, 64'h778899AABBCCDDEE);

    // Sub-doubleword and doubleword stores.
    do_req("sh10", 1'b1, 3'b001, 64'd10, 64'h1234);
    do_req("ld8b", 1'b0, 3'b011, 64'd8, 64'd0);  check("ld8b_k", last_rdata, 64'h778899AA1234DDEE);
    do_req("sd16", 1'b1, 3'b011, 64'd16, 64'h1122334455667788);
    do_req("ld16", 1'b0, 3'b011, 64'd16, 64'd0); check("ld16_k", last_rdata, 64'h1122334455667788);

    // Faults.
    do_req("lw2", 1'b0, 3'b010, 64'd2, 64'd0);
    do_req("st100", 1'b1, 3'b100, 64'd24, 64'hDEAD);
    do_req("ld111", 1'b0, 3'b111, 64'd32, 64'd0);

    // Reset sampled during the RD cycle of an SB.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'h55;
    check("rmw_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_rd_wrt_en", mem_wrt_en, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_resp", resp_valid, 1'b0);
    check("rmw_rst_wrt_en", mem_wrt_en, 1'b0);
    check("rmw_rst_ready", req_ready, 1'b0);
    check("rmw_rst_address", mem_address, 64'd0);
    rst = 1'b0;
    events = 0;
    for (int k = 0; k < 4; k++) begin
      #1 if (mem_wrt_en || resp_valid) events++;
      @(negedge clk);
    end
    check("rmw_no_events", events, 0);
    check("rmw_mem0", dmem[0], 64'hFFAAFFAAFFAAFFAA);

    // Back-to-back: req_valid held for LD@0 then SW@4.
    exp1 = ref_load(3'b011, 0);
    wd2 = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'd0;
    check("b2b_ready0", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 64'd4; req_wdata = wd2;
    check("b2b_busy_rd", req_ready, 1'b0);
    @(negedge clk);
    check("b2b_resp1", resp_valid, 1'b1);
    check("b2b_rdata1", resp_rdata, exp1);
    check("b2b_busy_resp", req_ready, 1'b0);
    @(negedge clk);
    check("b2b_ready1", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_rd2_wrt_en", mem_wrt_en, 1'b0);
    @(negedge clk);
    check("b2b_wr2_wrt_en", mem_wrt_en, 1'b1);
    check("b2b_wr2_addr", mem_address, 64'd0);
    ref_store(3'b010, 4, wd2);
    @(negedge clk);
    check("b2b_resp2", resp_valid, 1'b1);
    check("b2b_rdata2", resp_rdata, 64'd0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 250; t++) begin
      logic st;
      logic [2:0] f3;
      int n;
      int off;
      int base;
      st = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      else    f3 = 3'($urandom_range(0, 7));
      n = 1 << f3[1:0];
      base = $urandom_range(0, 63) * 8;
      off = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 7) & ~(n - 1)) : $urandom_range(0, 7);
      do_req("rnd", st, f3, 64'(base + off), {$urandom, $urandom});
    end

    // Final memory contents.
    for (int w = 0; w < 64; w++) check("final_mem", dmem[w], ref_word(w));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog for any unexpected stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
